// File: rtl/sprite_move_input_if.sv
// Button/move handshake bundle between the push-button pad side and spriteFSM.
interface sprite_move_input_if;
   logic [3:0] btn;
   logic       ready;
   logic       move;
   logic [1:0] dir;
   logic       held;

   modport master (output btn, output ready, input move, input dir, input held);
   modport slave  (input btn, input ready, output move, output dir, output held);
endinterface

// File: rtl/sprite_move_input.sv
// Push-button conditioner: sync, debounce, priority, one move pulse per press.
// Define SPRITE_MOVE_AUTOREPEAT_EN to auto-repeat moves while a button is held.
module sprite_move_input #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000,
   parameter int unsigned CNT_W           = 25
) (
   input logic                i_clock,
   input logic                i_reset,
   sprite_move_input_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_HOLD} state_t;

   localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       r_sync1;
   logic [3:0]       r_sync2;
   logic [3:0]       r_db;
   logic [CNT_W-1:0] r_db_cnt [4];
   logic [3:0]       w_db_nxt;
   logic [CNT_W-1:0] w_cnt_nxt [4];

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_req_dir;
   logic [1:0]       w_req_dir_nxt;
   logic             r_move;
   logic             w_move_nxt;
   logic [1:0]       r_dir;
   logic [1:0]       w_dir_nxt;
   logic             w_any;
   logic [1:0]       w_win;
   logic             w_new;
   logic             w_keep;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= bus.btn;
         r_sync2 <= r_sync1;
      end
   end

   // Counter only runs while the synced level disagrees; it flips on the last stable cycle.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_db_nxt[i]  = r_db[i];
         w_cnt_nxt[i] = '0;
         if (r_sync2[i] != r_db[i]) begin
            if (r_db_cnt[i] == DB_MAX)
               w_db_nxt[i] = ~r_db[i];
            else
               w_cnt_nxt[i] = r_db_cnt[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_db <= '0;
         for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
      end else begin
         r_db <= w_db_nxt;
         for (int i = 0; i < 4; i++) r_db_cnt[i] <= w_cnt_nxt[i];
      end
   end

   // The FSM looks at the level being accepted this edge, saving one cycle of latency.
   always_comb begin
      w_any = |w_db_nxt;
      w_win = 2'd0;
      priority case (1'b1)
         w_db_nxt[0]: w_win = 2'd0;
         w_db_nxt[1]: w_win = 2'd1;
         w_db_nxt[2]: w_win = 2'd2;
         w_db_nxt[3]: w_win = 2'd3;
         default:     w_win = 2'd0;
      endcase
   end

   assign w_new  = ((r_state == S_IDLE) && w_any) ||
                   ((r_state == S_HOLD) && w_any && (w_win != r_req_dir));
   assign w_keep = (r_state == S_HOLD) && w_any && (w_win == r_req_dir);

`ifdef SPRITE_MOVE_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] DLY_MAX = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(REPEAT_PERIOD - 1);

   logic [CNT_W-1:0] r_rep_cnt;
   logic             r_first_done;
   logic             w_rep_hit;

   assign w_rep_hit = r_rep_cnt == (r_first_done ? PER_MAX : DLY_MAX);

   // Counter stops at its threshold because a hit always leaves HOLD.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rep_cnt    <= '0;
         r_first_done <= 1'b0;
      end else begin
         if ((r_state == S_PEND) && bus.ready)
            r_rep_cnt <= '0;
         else if (w_keep && !w_rep_hit)
            r_rep_cnt <= r_rep_cnt + 1'b1;
         if (w_new)
            r_first_done <= 1'b0;
         else if (w_keep && w_rep_hit)
            r_first_done <= 1'b1;
      end
   end
`else
   logic w_rep_hit;
   assign w_rep_hit = 1'b0;
`endif

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_req_dir <= 2'd0;
         r_move    <= 1'b0;
         r_dir     <= 2'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_req_dir <= w_req_dir_nxt;
         r_move    <= w_move_nxt;
         r_dir     <= w_dir_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_state_nxt = S_PEND;
         S_PEND:  if (bus.ready) w_state_nxt = S_HOLD;
         S_HOLD: begin
            if (!w_any)                  w_state_nxt = S_IDLE;
            else if (w_win != r_req_dir) w_state_nxt = S_PEND;
            else if (w_rep_hit)          w_state_nxt = S_PEND;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_move_nxt    = (r_state == S_PEND) && bus.ready;
      w_req_dir_nxt = w_new ? w_win : r_req_dir;
      w_dir_nxt     = w_move_nxt ? r_req_dir : r_dir;
   end

   assign bus.move = r_move;
   assign bus.dir  = r_dir;
   assign bus.held = |r_db;

endmodule

// File: tb/tb_sprite_move_input.sv
// Directed bench for sprite_move_input (DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
// Expectations follow SPRITE_MOVE_AUTOREPEAT_EN when it is defined.
module tb_sprite_move_input;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   sprite_move_input_if bus ();

   sprite_move_input #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(20),
      .REPEAT_PERIOD(8),
      .CNT_W(25)
   ) dut (
      .i_clock(clk),
      .i_reset(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.btn   = 4'b0000;
      bus.ready = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (bus.move !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_move got %b want 0", bus.move);
      end
      n_tests++;
      if (bus.dir !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_dir got %b want 00", bus.dir);
      end
      n_tests++;
      if (bus.held !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_held got %b want 0", bus.held);
      end
   endtask

   task automatic test_single();
      int first_k = -1;
      logic [1:0] first_dir = 2'b00;
      int cnt = 0;
      int consec = 0;
      logic prev = 1'b0;
      logic held10 = 1'b0;
      logic held45 = 1'b1;
      int exp_cnt;
`ifdef SPRITE_MOVE_AUTOREPEAT_EN
      exp_cnt = 2;
`else
      exp_cnt = 1;
`endif
      do_reset();
      bus.btn = 4'b0001;
      for (int k = 1; k <= 45; k++) begin
         tick();
         if (bus.move) begin
            if (first_k < 0) begin
               first_k = k;
               first_dir = bus.dir;
            end
            cnt++;
            if (prev) consec++;
         end
         prev = bus.move;
         if (k == 10) held10 = bus.held;
         if (k == 45) held45 = bus.held;
         if (k == 30) bus.btn = 4'b0000;
      end
      n_tests++;
      if (first_k !== 7) begin
         n_fail++;
         $display("FAIL single_latency got %0d want 7", first_k);
      end
      n_tests++;
      if (first_dir !== 2'b00) begin
         n_fail++;
         $display("FAIL single_dir got %b want 00", first_dir);
      end
      n_tests++;
      if (cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL single_count got %0d want %0d", cnt, exp_cnt);
      end
      n_tests++;
      if (consec !== 0) begin
         n_fail++;
         $display("FAIL single_width got %0d wide pulses want 0", consec);
      end
      n_tests++;
      if (held10 !== 1'b1) begin
         n_fail++;
         $display("FAIL single_held got %b want 1", held10);
      end
      n_tests++;
      if (held45 !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release_held got %b want 0", held45);
      end
   endtask

   task automatic test_glitch();
      int moves = 0;
      int held_cycles = 0;
      do_reset();
      bus.btn = 4'b0100;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus.move) moves++;
         if (bus.held) held_cycles++;
         if (k == 3) bus.btn = 4'b0000;
      end
      n_tests++;
      if (moves !== 0) begin
         n_fail++;
         $display("FAIL glitch_move got %0d want 0", moves);
      end
      n_tests++;
      if (held_cycles !== 0) begin
         n_fail++;
         $display("FAIL glitch_held got %0d cycles want 0", held_cycles);
      end
   endtask

   task automatic test_priority();
      int mk [4];
      logic [1:0] md [4];
      int cnt = 0;
      do_reset();
      bus.btn = 4'b1010;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus.move) begin
            if (cnt < 4) begin
               mk[cnt] = k;
               md[cnt] = bus.dir;
            end
            cnt++;
         end
         if (k == 15) bus.btn = 4'b1000;
         if (k == 25) bus.btn = 4'b0000;
      end
      n_tests++;
      if (cnt !== 2) begin
         n_fail++;
         $display("FAIL prio_count got %0d want 2", cnt);
      end else begin
         n_tests++;
         if (mk[0] !== 7 || md[0] !== 2'b01) begin
            n_fail++;
            $display("FAIL prio_first got k=%0d dir=%b want k=7 dir=01", mk[0], md[0]);
         end
         n_tests++;
         if (mk[1] !== 22 || md[1] !== 2'b11) begin
            n_fail++;
            $display("FAIL prio_change got k=%0d dir=%b want k=22 dir=11", mk[1], md[1]);
         end
      end
   endtask

   task automatic test_ready_hold();
      int cnt = 0;
      int first_k = -1;
      logic [1:0] first_dir = 2'b11;
      logic held30 = 1'b1;
      do_reset();
      bus.ready = 1'b0;
      bus.btn = 4'b0001;
      for (int k = 1; k <= 55; k++) begin
         tick();
         if (bus.move) begin
            if (first_k < 0) begin
               first_k = k;
               first_dir = bus.dir;
            end
            cnt++;
         end
         if (k == 30) held30 = bus.held;
         if (k == 10) bus.btn = 4'b0000;
         if (k == 40) bus.ready = 1'b1;
      end
      n_tests++;
      if (cnt !== 1) begin
         n_fail++;
         $display("FAIL ready_count got %0d want 1", cnt);
      end
      n_tests++;
      if (first_k !== 41) begin
         n_fail++;
         $display("FAIL ready_when got %0d want 41", first_k);
      end
      n_tests++;
      if (first_dir !== 2'b00) begin
         n_fail++;
         $display("FAIL ready_dir got %b want 00", first_dir);
      end
      n_tests++;
      if (held30 !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_held got %b want 0", held30);
      end
   endtask

   task automatic test_autorepeat();
      int exp_k [6];
      int exp_n;
      int got_k [8];
      logic [1:0] got_d [8];
      int cnt = 0;
      int consec = 0;
      logic prev = 1'b0;
`ifdef SPRITE_MOVE_AUTOREPEAT_EN
      exp_k = '{7, 28, 37, 46, 55, 64};
      exp_n = 6;
`else
      exp_k = '{7, 0, 0, 0, 0, 0};
      exp_n = 1;
`endif
      do_reset();
      bus.btn = 4'b0100;
      for (int k = 1; k <= 75; k++) begin
         tick();
         if (bus.move) begin
            if (cnt < 8) begin
               got_k[cnt] = k;
               got_d[cnt] = bus.dir;
            end
            cnt++;
            if (prev) consec++;
         end
         prev = bus.move;
         if (k == 60) bus.btn = 4'b0000;
      end
      n_tests++;
      if (cnt !== exp_n) begin
         n_fail++;
         $display("FAIL repeat_count got %0d want %0d", cnt, exp_n);
      end else begin
         for (int i = 0; i < exp_n; i++) begin
            n_tests++;
            if (got_k[i] !== exp_k[i] || got_d[i] !== 2'b10) begin
               n_fail++;
               $display("FAIL repeat_pulse%0d got k=%0d dir=%b want k=%0d dir=10",
                        i, got_k[i], got_d[i], exp_k[i]);
            end
         end
      end
      n_tests++;
      if (consec !== 0) begin
         n_fail++;
         $display("FAIL repeat_width got %0d back-to-back want 0", consec);
      end
   endtask

   task automatic test_reset_pending();
      int bad = 0;
      logic held_pre;
      do_reset();
      bus.ready = 1'b0;
      bus.btn = 4'b0001;
      for (int k = 1; k <= 10; k++) tick();
      held_pre = bus.held;
      n_tests++;
      if (held_pre !== 1'b1) begin
         n_fail++;
         $display("FAIL rstpend_setup_held got %b want 1", held_pre);
      end
      rst = 1'b1;
      bus.btn = 4'b0000;
      tick();
      n_tests++;
      if (bus.move !== 1'b0 || bus.held !== 1'b0) begin
         n_fail++;
         $display("FAIL rstpend_in_reset got move=%b held=%b want 0 0", bus.move, bus.held);
      end
      rst = 1'b0;
      bus.ready = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus.move !== 1'b0 || bus.dir !== 2'b00 || bus.held !== 1'b0) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL rstpend_after got %0d bad cycles want 0", bad);
      end
   endtask

   initial begin
      bus.btn   = 4'b0000;
      bus.ready = 1'b1;
      test_reset();
      test_single();
      test_glitch();
      test_priority();
      test_ready_hold();
      test_autorepeat();
      test_reset_pending();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
